// File: rtl/obd_response_parser.sv
// obd_response_parser: drains the UART RX FIFO and parses ELM327-style "41 PP DD..\r" lines.
// Optional idle-abort timer is built in when PARSER_TIMEOUT_EN is defined.
module obd_response_parser #(
  parameter int DATA_BYTES  = 4,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_empty,
  input  logic [7:0]              r_data,
  output logic                    rd_uart,
  output logic [7:0]              pid,
  output logic [8*DATA_BYTES-1:0] data_val,
  output logic [2:0]              data_len,
  output logic                    done_tick,
  output logic                    err_tick,
  output logic                    prompt_tick
);

  localparam int         DW      = 8 * DATA_BYTES;
  localparam logic [3:0] MAX_CNT = 4'(DATA_BYTES + 2);

  if (DATA_BYTES < 1 || DATA_BYTES > 7) begin : g_bad_data_bytes
    $error("obd_response_parser: DATA_BYTES must be in 1..7");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("obd_response_parser: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_LO, S_DISCARD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    nib_q, nib_d;
  logic [7:0]    mode_q, mode_d;
  logic [7:0]    line_pid_q, line_pid_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [7:0]    pid_q, pid_d;
  logic [DW-1:0] data_val_q, data_val_d;
  logic [2:0]    data_len_q, data_len_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          prompt_q, prompt_d;

  logic       is_hex, is_sp, is_cr, is_lf, is_pr;
  logic [3:0] hex_val;
  logic [7:0] asm_byte;
  logic       clear_line;
  logic       tmo_hit;

  // Popping is blocked while reset is held so no FIFO byte is lost.
  assign rd_uart  = ~rx_empty & ~reset;
  assign asm_byte = {nib_q, hex_val};

  always_comb begin
    is_hex  = 1'b0;
    hex_val = 4'h0;
    if (r_data >= 8'h30 && r_data <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = 4'(r_data - 8'h30);
    end else if (r_data >= 8'h41 && r_data <= 8'h46) begin
      is_hex  = 1'b1;
      hex_val = 4'(r_data - 8'h37);
    end else if (r_data >= 8'h61 && r_data <= 8'h66) begin
      is_hex  = 1'b1;
      hex_val = 4'(r_data - 8'h57);
    end
    is_sp = (r_data == 8'h20);
    is_cr = (r_data == 8'h0D);
    is_lf = (r_data == 8'h0A);
    is_pr = (r_data == 8'h3E);
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (rx_empty && (state_q != S_IDLE || cnt_q != 4'd0)) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) tmo_hit = 1'b1;
      else                               tmo_d   = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nib_d      = nib_q;
    mode_d     = mode_q;
    line_pid_d = line_pid_q;
    shift_d    = shift_q;
    pid_d      = pid_q;
    data_val_d = data_val_q;
    data_len_d = data_len_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    prompt_d   = 1'b0;
    clear_line = 1'b0;

    if (rd_uart) begin
      if (is_lf) begin
        state_d = state_q;
      end else if (is_pr) begin
        prompt_d   = 1'b1;
        err_d      = (state_q != S_IDLE) || (cnt_q != 4'd0);
        clear_line = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (is_hex) begin
              nib_d   = hex_val;
              state_d = S_LO;
            end else if (is_cr) begin
              if (cnt_q != 4'd0) begin
                if (cnt_q >= 4'd3 && mode_q == 8'h41) begin
                  done_d     = 1'b1;
                  pid_d      = line_pid_q;
                  data_val_d = shift_q;
                  data_len_d = 3'(cnt_q - 4'd2);
                end else begin
                  err_d = 1'b1;
                end
                clear_line = 1'b1;
              end
            end else if (!is_sp) begin
              state_d = S_DISCARD;
            end
          end
          S_LO: begin
            if (is_hex) begin
              if (cnt_q == MAX_CNT) begin
                state_d = S_DISCARD;
              end else begin
                if (cnt_q == 4'd0)      mode_d     = asm_byte;
                else if (cnt_q == 4'd1) line_pid_d = asm_byte;
                else                    shift_d    = (shift_q << 8) | DW'(asm_byte);
                cnt_d   = cnt_q + 4'd1;
                state_d = S_IDLE;
              end
            end else if (is_cr) begin
              err_d      = 1'b1;
              clear_line = 1'b1;
            end else begin
              state_d = S_DISCARD;
            end
          end
          S_DISCARD: begin
            if (is_cr) begin
              err_d      = 1'b1;
              clear_line = 1'b1;
            end
          end
          default: clear_line = 1'b1;
        endcase
      end
    end else if (tmo_hit) begin
      err_d      = 1'b1;
      clear_line = 1'b1;
    end

    // Shift register restarts at zero so data_val stays right-aligned and zero-extended.
    if (clear_line) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      shift_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      nib_q      <= 4'h0;
      mode_q     <= 8'h00;
      line_pid_q <= 8'h00;
      shift_q    <= '0;
      pid_q      <= 8'h00;
      data_val_q <= '0;
      data_len_q <= 3'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      prompt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nib_q      <= nib_d;
      mode_q     <= mode_d;
      line_pid_q <= line_pid_d;
      shift_q    <= shift_d;
      pid_q      <= pid_d;
      data_val_q <= data_val_d;
      data_len_q <= data_len_d;
      done_q     <= done_d;
      err_q      <= err_d;
      prompt_q   <= prompt_d;
    end
  end

  assign pid         = pid_q;
  assign data_val    = data_val_q;
  assign data_len    = data_len_q;
  assign done_tick   = done_q;
  assign err_tick    = err_q;
  assign prompt_tick = prompt_q;

endmodule

// File: tb/tb_obd_response_parser.sv
// Self-checking bench for obd_response_parser: directed lines plus random lines checked
// against a line-level string model.
module tb_obd_response_parser;

  localparam int DB = 4;
  localparam int DW = 8 * DB;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_empty;
  logic [7:0]    r_data;
  logic          rd_uart;
  logic [7:0]    pid;
  logic [DW-1:0] data_val;
  logic [2:0]    data_len;
  logic          done_tick;
  logic          err_tick;
  logic          prompt_tick;

  always #5 clk = ~clk;

  obd_response_parser #(.DATA_BYTES(DB), .TIMEOUT_CYC(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .pid        (pid),
    .data_val   (data_val),
    .data_len   (data_len),
    .done_tick  (done_tick),
    .err_tick   (err_tick),
    .prompt_tick(prompt_tick)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]    line_buf[$];
  logic [7:0]    stim_q[$];
  logic [7:0]    m_pid;
  logic [DW-1:0] m_val;
  logic [2:0]    m_len;
  logic          e_done, e_err, e_prompt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hex_of(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hex_ch(input logic [3:0] v, input bit lower);
    if (v < 4'd10) return 8'h30 + 8'(v);
    return lower ? 8'h57 + 8'(v) : 8'h37 + 8'(v);
  endfunction

  function automatic bit has_content();
    foreach (line_buf[i]) if (line_buf[i] != 8'h20) return 1'b1;
    return 1'b0;
  endfunction

  // A line is good when it holds only hex and spaces, every hex run has even length,
  // it carries 3..DB+2 bytes, and the first byte is 0x41.
  task automatic evaluate_line();
    logic [7:0] bytes[$];
    bit ok;
    int pend;
    int h;
    ok   = 1'b1;
    pend = -1;
    foreach (line_buf[i]) begin
      h = hex_of(line_buf[i]);
      if (h >= 0) begin
        if (pend < 0) pend = h;
        else begin
          bytes.push_back(8'(pend * 16 + h));
          pend = -1;
        end
      end else if (line_buf[i] != 8'h20 || pend >= 0) begin
        ok = 1'b0;
      end
    end
    if (pend >= 0) ok = 1'b0;
    if (bytes.size() > DB + 2) ok = 1'b0;
    if (ok && bytes.size() >= 3 && bytes[0] == 8'h41) begin
      e_done = 1'b1;
      m_pid  = bytes[1];
      m_val  = '0;
      for (int k = 2; k < bytes.size(); k++) m_val = m_val * 256 + DW'(bytes[k]);
      m_len = 3'(bytes.size() - 2);
    end else begin
      e_err = 1'b1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    e_done   = 1'b0;
    e_err    = 1'b0;
    e_prompt = 1'b0;
    if (b == 8'h0A) return;
    if (b == 8'h3E) begin
      e_prompt = 1'b1;
      e_err    = has_content();
      line_buf.delete();
    end else if (b == 8'h0D) begin
      if (has_content()) evaluate_line();
      line_buf.delete();
    end else begin
      line_buf.push_back(b);
    end
  endtask

  task automatic model_reset();
    line_buf.delete();
    m_pid = 8'h00;
    m_val = '0;
    m_len = 3'd0;
  endtask

  task automatic check_outputs();
    check("pid", pid, m_pid);
    check("data_val", data_val, m_val);
    check("data_len", data_len, m_len);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_empty = 1'b0;
    r_data   = b;
    #1 check("rd_uart_pop", rd_uart, 1'b1);
    model_byte(b);
    @(posedge clk);
    #1;
    rx_empty = 1'b1;
    check("done_tick", done_tick, e_done);
    check("err_tick", err_tick, e_err);
    check("prompt_tick", prompt_tick, e_prompt);
    check("tick_exclusive", done_tick & err_tick, 1'b0);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_empty = 1'b1;
      #1 check("rd_uart_idle", rd_uart, 1'b0);
      @(posedge clk);
      #1 check("ticks_idle", {done_tick, err_tick, prompt_tick}, 3'b000);
    end
  endtask

  task automatic send_q(input int gap);
    logic [7:0] b;
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      send_byte(b);
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  task automatic send_line(input string s, input bit cr, input int gap);
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    if (cr) stim_q.push_back(8'h0D);
    send_q(gap);
  endtask

  task automatic push_hex_byte(input logic [7:0] b);
    stim_q.push_back(hex_ch(b[7:4], bit'($urandom_range(0, 1))));
    stim_q.push_back(hex_ch(b[3:0], bit'($urandom_range(0, 1))));
  endtask

  int         nb;
  int         pos;
  int         err_cnt;
  logic [7:0] rb;

  initial begin
    reset    = 1'b1;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    model_reset();
    #1;
    check("reset_rd_uart", rd_uart, 1'b0);
    check("reset_ticks", {done_tick, err_tick, prompt_tick}, 3'b000);
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Back-to-back good line, then lowercase line with LF, then a lone CR.
    send_line("41 0B 7F", 1'b1, 0);
    check("tp1_val", data_val, 32'h0000_007F);
    send_line("41 0c 1a f8", 1'b1, 0);
    send_byte(8'h0A);
    check("tp2_val", data_val, 32'h0000_1AF8);
    send_line("", 1'b1, 0);

    // Malformed lines leave the last good values alone.
    send_line("NO DATA", 1'b1, 1);
    send_line("41 0B 7", 1'b1, 1);
    send_line("41 05 11 22 33 44 55", 1'b1, 0);
    send_line("42 0B 10", 1'b1, 0);
    send_line("41 0B", 1'b1, 0);
    check("tp3_pid_held", pid, 8'h0C);

    // Prompt aborting a partial line, then recovery.
    send_line("41 0B 3", 1'b0, 0);
    send_byte(8'h3E);
    send_line("41 0F 55", 1'b1, 0);
    check("tp4_pid", pid, 8'h0F);
    send_byte(8'h3E);

    // Reset mid-line.
    send_line("41 0B", 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("midreset_ticks", {done_tick, err_tick, prompt_tick}, 3'b000);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    send_line("41 11 80", 1'b1, 0);
    check("tp5_val", data_val, 32'h0000_0080);

`ifdef PARSER_TIMEOUT_EN
    send_line("41 0B", 1'b0, 0);
    err_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk);
      #1 if (err_tick) err_cnt++;
    end
    check("timeout_err_count", err_cnt, 1);
    line_buf.delete();
    send_line("41 22 01 02", 1'b1, 0);
`endif

    // Random lines: byte count, mode, separators, corruption and terminator all vary.
    for (int ln = 0; ln < 250; ln++) begin
      stim_q.delete();
      nb = $urandom_range(0, DB + 3);
      for (int k = 0; k < nb; k++) begin
        if (k == 0) rb = ($urandom_range(0, 3) != 0) ? 8'h41 : 8'($urandom);
        else        rb = 8'($urandom);
        if (k > 0 || $urandom_range(0, 3) == 0)
          repeat ($urandom_range(0, 2)) stim_q.push_back(8'h20);
        push_hex_byte(rb);
      end
      pos = $urandom_range(0, stim_q.size());
      case ($urandom_range(0, 9))
        0: stim_q.insert(pos, hex_ch(4'($urandom), 1'b0));
        1: stim_q.insert(pos, 8'h47 + 8'($urandom_range(0, 19)));
        2: stim_q.insert(pos, 8'h0A);
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) stim_q.push_back(8'h3E);
      else begin
        stim_q.push_back(8'h0D);
        if ($urandom_range(0, 1) == 1) stim_q.push_back(8'h0A);
      end
      send_q($urandom_range(0, 2));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obd_response_parser.md
Name: obd_response_parser

Overview:
Reader end of the ELM327-style command link. The MCU writes PID request strings out through the UART. This block drains the UART RX FIFO and parses ASCII hex response lines of the form "41 PP DD [DD..]\r". It emits the PID, the right-aligned data value, a byte count, and done/error/prompt ticks for the MCU and gauge logic.

Parameters:
DATA_BYTES, 4, max data bytes per response after mode and PID; legal range 1..7.
TIMEOUT_CYC, 5_000_000, idle-cycle limit before a partial line is aborted (100 ms at 50 MHz); used only with PARSER_TIMEOUT_EN.

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
rx_empty  input  1  UART RX FIFO empty flag
r_data  input  8  UART RX FIFO head byte, valid whenever rx_empty=0
rd_uart  output  1  FIFO pop strobe; r_data is consumed in the same cycle
pid  output  8  PID byte of the last good line
data_val  output  8*DATA_BYTES  data bytes, first received byte most significant, right-aligned, zero-extended
data_len  output  3  number of data bytes in the last good line (1..DATA_BYTES)
done_tick  output  1  one-cycle pulse: pid/data_val/data_len updated
err_tick  output  1  one-cycle pulse: malformed or aborted line
prompt_tick  output  1  one-cycle pulse: '>' received (adapter ready)

Behaviour:
- Reset: all outputs 0, FSM in S_IDLE, byte count 0, shift register 0. Async assert; recovery is synchronous to clk.
- Handshake: rd_uart = ~rx_empty (combinational from state-independent FIFO flag). The byte is processed in the cycle rd_uart=1. Throughput is 1 byte/clk; there is no backpressure.
- Character classes:
  - HEX: '0'-'9', 'A'-'F', 'a'-'f'
  - SP: 0x20
  - CR: 0x0D
  - LF: 0x0A (ignored in every state, no effect)
  - PR: '>' 0x3E
  - anything else is OTHER
- Per line: a byte count (0..DATA_BYTES+2) and a nibble register. Byte 0 is the mode byte, byte 1 the PID byte, bytes 2.. shift into data_val.
- S_IDLE:
  - HEX: store nibble, go to S_LO
  - SP: stay
  - CR with count=0: ignored, no tick
  - CR with count>0: finish the line (see below)
  - OTHER: go to S_DISCARD
- S_LO:
  - HEX: assemble the byte. Count 0 goes to the mode register, count 1 to the PID register, otherwise shift left 8 into data_val_next. Count+1, then go to S_IDLE.
  - If count would exceed DATA_BYTES+2: go to S_DISCARD.
  - SP, CR or OTHER (odd nibble): go to S_DISCARD. A CR here also ends the line with err_tick.
- S_DISCARD: wait for CR, then pulse err_tick, clear count, go to S_IDLE.
- Finish on CR from S_IDLE:
  - If count>=3 and mode==0x41: next cycle, pid/data_val/data_len are registered and done_tick=1.
  - Otherwise err_tick=1.
  - Either way, clear count and data shift register, go to S_IDLE.
- PR in any state:
  - prompt_tick=1.
  - If count>0 or state≠S_IDLE, the partial line is aborted with err_tick=1 in the same cycle.
  - Go to S_IDLE, count 0.
- Outputs pid/data_val/data_len hold their value until the next good line; error lines never modify them.
- Tick latency is 1 clk after the rd_uart cycle of the terminating byte. At most one of done_tick/err_tick is high in any cycle.
- Reset mid-line discards all partial state; there is no tick.

Optional Feature:
PARSER_TIMEOUT_EN:
- Defined: a counter is cleared on every popped byte and increments while rx_empty=1 with state≠S_IDLE or count>0. On reaching TIMEOUT_CYC-1 the line is aborted: err_tick pulses once, state goes to S_IDLE, count 0.
- Undefined: no counter. A partial line waits indefinitely for CR or '>'.

Test Plan:
- Stream "41 0B 7F\r" back-to-back (rx_empty=0 for 9 clk) -> rd_uart high 9 clk; one done_tick; pid=0x0B, data_val=0x0000007F, data_len=1.
- "41 0c 1a f8\r\n" -> done_tick; pid=0x0C, data_val=0x00001AF8, data_len=2; LF has no effect; a following "\r" alone produces no tick.
- "NO DATA\r", then "41 0B 7\r", then "41 05 11 22 33 44 55\r" (DATA_BYTES=4) -> three err_ticks. pid/data_val keep the prior values.
- "42 0B 10\r" -> err_tick; "41 0B\r" -> err_tick (count<3).
- "41 0B 3" then '>' -> prompt_tick and err_tick in the same cycle; a following "41 0F 55\r" -> done_tick, pid=0x0F, data_val=0x55.
- Assert reset mid "41 0B" -> all outputs 0; then "41 11 80\r" parses correctly. With PARSER_TIMEOUT_EN and TIMEOUT_CYC=100: "41 0B" then idle 100 clk -> exactly one err_tick.
